playback_sequencer: RTL and testbench

//   Sequences the sample-memory address for one audio playback segment.

---
 rtl/playback_pkg.sv | 10 +
 rtl/playback_sequencer_if.sv | 30 +++
 rtl/sample_tick_gen.sv | 34 +++
 rtl/playback_sequencer.sv | 112 +++++++++++
 tb/tb_playback_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared state type and default sizing for the playback sequencer
package playback_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_DEPTH   = 10000;
  localparam int DEFAULT_CLK_DIV = 500;

endpackage

// File: rtl/playback_sequencer_if.sv
// rtl/playback_sequencer_if.sv - command/read-port bundle; loop signal only with PLAYBACK_LOOP_EN
interface playback_sequencer_if #(
  parameter int ADDR_W = 16
) ();

  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] seg_start;
  logic [ADDR_W-1:0] seg_len;
`ifdef PLAYBACK_LOOP_EN
  logic              loop;
`endif
  logic [ADDR_W-1:0] address;
  logic              rd_en;
  logic              busy;
  logic              done;

`ifdef PLAYBACK_LOOP_EN
  modport master (output start, stop, seg_start, seg_len, loop,
                  input  address, rd_en, busy, done);
  modport slave  (input  start, stop, seg_start, seg_len, loop,
                  output address, rd_en, busy, done);
`else
  modport master (output start, stop, seg_start, seg_len,
                  input  address, rd_en, busy, done);
  modport slave  (input  start, stop, seg_start, seg_len,
                  output address, rd_en, busy, done);
`endif

endinterface

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - CLK_DIV divider producing a registered one-cycle sample tick
module sample_tick_gen #(
  parameter int CLK_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - steps sample-ROM address per tick, wraps at DEPTH; PLAYBACK_LOOP_EN adds segment repeat
module playback_sequencer
  import playback_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  playback_sequencer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic              busy_r;
  logic              done_r;
  logic              tick;
  logic              accept;
  logic              clear;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] next_addr;
`ifdef PLAYBACK_LOOP_EN
  logic [ADDR_W-1:0] lat_start;
  logic [ADDR_W-1:0] lat_len;
`endif

  assign accept     = (state == IDLE) && bus.start && !bus.stop;
  assign clear      = accept || bus.stop;
  assign first_addr = (bus.seg_start > LAST) ? '0 : bus.seg_start;
  assign next_addr  = (addr == LAST) ? '0 : addr + ADDR_W'(1);

  // Restarting the divider on every command keeps strobe phase relative to the start edge.
  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (state == PLAY),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
      lat_start <= '0;
      lat_len   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.seg_len == '0) begin
              done_r <= 1'b1;
            end else begin
              state     <= PLAY;
              busy_r    <= 1'b1;
              addr      <= first_addr;
              remaining <= bus.seg_len;
`ifdef PLAYBACK_LOOP_EN
              lat_start <= first_addr;
              lat_len   <= bus.seg_len;
`endif
            end
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (tick) begin
            addr      <= next_addr;
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              done_r <= 1'b1;
`ifdef PLAYBACK_LOOP_EN
              if (bus.loop) begin
                addr      <= lat_start;
                remaining <= lat_len;
              end else begin
                state  <= IDLE;
                busy_r <= 1'b0;
              end
`else
              state  <= IDLE;
              busy_r <= 1'b0;
`endif
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address = addr;
  assign bus.rd_en   = tick;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb/tb_playback_sequencer.sv - directed bench for playback_sequencer (CLK_DIV=4, DEPTH=10000)
module tb_playback_sequencer;

  logic clk;
  logic reset;

  playback_sequencer_if #(.ADDR_W(16)) bus ();

  playback_sequencer #(.ADDR_W(16), .DEPTH(10000), .CLK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int rd_q[$];
  int rd_t[$];
  int done_cnt = 0;
  int done_t   = 0;
  int busy_cnt = 0;

  int rb, db, bb, e0, n;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_en) begin
        rd_q.push_back(int'(bus.address));
        rd_t.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        done_t   = cyc;
      end
      if (bus.busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    rb = rd_q.size();
    db = done_cnt;
    bb = busy_cnt;
  endtask

  task automatic go(input int s, input int l);
    bus.seg_start = 16'(s);
    bus.seg_len   = 16'(l);
    bus.start     = 1'b1;
    step(1);
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (bus.busy && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, bus.busy, 0);
  endtask

  task automatic wait_rd(input int budget);
    int k = 0;
    while (!bus.rd_en && k < budget) begin
      step(1);
      k++;
    end
  endtask

  // Checks strobe count, addresses, 4-cycle cadence from the start edge and done count.
  task automatic check_run(input string tag, input int cnt, input int exp[8], input int dones);
    chk({tag, "_rd_count"}, rd_q.size() - rb, cnt);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), rd_q[rb + i], exp[i]);
      chk($sformatf("%s_time%0d", tag, i), rd_t[rb + i] - e0, 4 * (i + 1));
    end
    chk({tag, "_done_count"}, done_cnt - db, dones);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.seg_start = '0;
    bus.seg_len   = '0;
`ifdef PLAYBACK_LOOP_EN
    bus.loop      = 1'b0;
`endif

    // 1: reset and idle
    step(3);
    chk("rst_address", bus.address, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;
    mark();
    step(20);
    chk("idle_address", bus.address, 0);
    chk("idle_rd_count", rd_q.size() - rb, 0);
    chk("idle_done_count", done_cnt - db, 0);
    chk("idle_busy_cycles", busy_cnt - bb, 0);

    // 2: basic segment
    mark();
    go(5, 3);
    chk("t2_busy_on", bus.busy, 1);
    chk("t2_addr_latched", bus.address, 5);
    step(3);
    chk("t2_no_early_rd", bus.rd_en, 0);
    step(1);
    chk("t2_first_rd", bus.rd_en, 1);
    wait_idle(40, "t2_idle");
    step(2);
    check_run("t2", 3, '{5, 6, 7, 0, 0, 0, 0, 0}, 1);
    chk("t2_done_after_last", done_t - rd_t[rb + 2], 1);
    chk("t2_final_addr", bus.address, 8);

    // 3: wrap through DEPTH-1
    mark();
    go(9998, 4);
    wait_idle(60, "t3_idle");
    step(2);
    check_run("t3", 4, '{9998, 9999, 0, 1, 0, 0, 0, 0}, 1);
    chk("t3_final_addr", bus.address, 2);

    // 4: start mid-PLAY ignored, stop in 2nd strobe cycle
    mark();
    go(20, 10);
    wait_rd(20);
    bus.seg_start = 16'd500;
    bus.seg_len   = 16'd1;
    bus.start     = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_rd(20);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("t4_busy_after_stop", bus.busy, 0);
    chk("t4_rd_after_stop", bus.rd_en, 0);
    chk("t4_addr_hold", bus.address, 21);
    step(20);
    check_run("t4", 2, '{20, 21, 0, 0, 0, 0, 0, 0}, 0);

    // start and stop together in IDLE
    mark();
    bus.seg_start = 16'd3;
    bus.seg_len   = 16'd2;
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("t4b_busy", bus.busy, 0);
    step(15);
    chk("t4b_rd_count", rd_q.size() - rb, 0);
    chk("t4b_done_count", done_cnt - db, 0);
    chk("t4b_addr", bus.address, 21);

    // 5: zero-length segment
    mark();
    go(7, 0);
    chk("t5_done_pulse", bus.done, 1);
    chk("t5_busy", bus.busy, 0);
    step(1);
    chk("t5_done_clear", bus.done, 0);
    step(10);
    chk("t5_rd_count", rd_q.size() - rb, 0);
    chk("t5_done_count", done_cnt - db, 1);
    chk("t5_busy_cycles", busy_cnt - bb, 0);
    chk("t5_addr", bus.address, 21);

    // reset mid-PLAY
    go(40, 5);
    wait_rd(20);
    chk("t5r_rd_before", bus.rd_en, 1);
    reset = 1'b1;
    step(1);
    chk("t5r_address", bus.address, 0);
    chk("t5r_rd_en", bus.rd_en, 0);
    chk("t5r_busy", bus.busy, 0);
    chk("t5r_done", bus.done, 0);
    reset = 1'b0;
    step(10);
    chk("t5r_still_idle", bus.busy, 0);

`ifdef PLAYBACK_LOOP_EN
    // 6: looped segment, release loop after two passes
    mark();
    bus.loop = 1'b1;
    go(100, 2);
    n = 0;
    while ((done_cnt - db) < 2 && n < 60) begin
      step(1);
      n++;
    end
    chk("t6_busy_looping", bus.busy, 1);
    bus.loop = 1'b0;
    wait_idle(60, "t6_idle");
    step(2);
    check_run("t6", 6, '{100, 101, 100, 101, 100, 101, 0, 0}, 3);
    chk("t6_final_addr", bus.address, 102);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
